// File: rtl/sc_ifu_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and instruction memory.
interface sc_ifu_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/sc_ifu.sv
// Instruction fetch unit: holds the PC, fetches over a req/ack bus and selects the next PC.
// Optional misaligned-target fault detection is enabled with `define IFU_ALIGN_CHECK_EN.
module sc_ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        advance,
  sc_ifu_if.master    imem,
  output logic [31:0] inst,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] p4,
`ifdef IFU_ALIGN_CHECK_EN
  output logic        fault,
`endif
  output logic [31:0] icount
);

`ifdef IFU_ALIGN_CHECK_EN
  typedef enum logic [1:0] {START, REQ, HOLD, FAULT} state_t;
`else
  typedef enum logic [1:0] {START, REQ, HOLD} state_t;
`endif

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] inst_nxt;
  logic [31:0] icount_nxt;
  logic [31:0] npc;
  logic        req;

  assign p4   = pc + 32'd4;
  assign op   = inst[31:26];
  assign func = inst[5:0];

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  always_comb begin
    case (pcsource)
      2'b00:   npc = p4;
      2'b01:   npc = bpc;
      2'b10:   npc = rpc;
      default: npc = jpc;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    inst_nxt   = inst;
    icount_nxt = icount;
    case (state)
      START: state_nxt = REQ;
      REQ: begin
        if (imem.imem_ack) begin
          inst_nxt  = imem.imem_rdata;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (advance) begin
          icount_nxt = icount + 32'd1;
`ifdef IFU_ALIGN_CHECK_EN
          // The misaligned target is kept in pc so software can see where it faulted
          pc_nxt    = npc;
          state_nxt = (npc[1:0] != 2'b00) ? FAULT : REQ;
`else
          pc_nxt    = npc & ~32'h3;
          state_nxt = REQ;
`endif
        end
      end
`ifdef IFU_ALIGN_CHECK_EN
      FAULT: state_nxt = FAULT;
`endif
      default: state_nxt = START;
    endcase
  end

  // Handshake outputs are registered from the next state so they are glitch-free
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= START;
      pc         <= RESET_PC;
      inst       <= 32'd0;
      icount     <= 32'd0;
      req        <= 1'b0;
      inst_valid <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
      fault      <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      inst       <= inst_nxt;
      icount     <= icount_nxt;
      req        <= (state_nxt == REQ);
      inst_valid <= (state_nxt == HOLD);
`ifdef IFU_ALIGN_CHECK_EN
      fault      <= (state_nxt == FAULT);
`endif
    end
  end

endmodule

// File: tb/tb_sc_ifu.sv
// Directed self-checking bench for sc_ifu with RESET_PC = 0x40.
module tb_sc_ifu;
  logic        clock;
  logic        reset;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic        advance;
  logic [31:0] inst, pc, p4, icount;
  logic [5:0]  op, func;
  logic        inst_valid;
`ifdef IFU_ALIGN_CHECK_EN
  logic        fault;
`endif

  int checks = 0;
  int errors = 0;

  sc_ifu_if imem ();

  sc_ifu #(.RESET_PC(32'h0000_0040)) dut (
    .clock      (clock),
    .reset      (reset),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .advance    (advance),
    .imem       (imem),
    .inst       (inst),
    .op         (op),
    .func       (func),
    .inst_valid (inst_valid),
    .pc         (pc),
    .p4         (p4),
`ifdef IFU_ALIGN_CHECK_EN
    .fault      (fault),
`endif
    .icount     (icount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_addr [4];
  logic [31:0] held;

  initial begin
    exp_addr[0] = 32'h44;  exp_addr[1] = 32'h100;
    exp_addr[2] = 32'h200; exp_addr[3] = 32'h300;
    reset = 1'b1; pcsource = 2'b00; advance = 1'b0;
    bpc = 32'h100; rpc = 32'h200; jpc = 32'h300;
    imem.imem_ack = 1'b0; imem.imem_rdata = 32'd0;
    tick(); tick();

    check("rst_req", {31'd0, imem.imem_req}, 32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_pc", pc, 32'h40);
    check("rst_inst", inst, 32'd0);
    check("rst_icount", icount, 32'd0);

    reset = 1'b0;
    tick();
    check("start_req", {31'd0, imem.imem_req}, 32'd1);
    check("start_addr", imem.imem_addr, 32'h40);

    // Three cycles without ack
    for (int i = 0; i < 3; i++) begin
      check("wait_addr", imem.imem_addr, 32'h40);
      check("wait_valid", {31'd0, inst_valid}, 32'd0);
      tick();
    end
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h2008_0005;
    tick();
    imem.imem_ack = 1'b0;
    check("ack_valid", {31'd0, inst_valid}, 32'd1);
    check("ack_inst", inst, 32'h2008_0005);
    check("ack_op", {26'd0, op}, 32'h08);
    check("ack_func", {26'd0, func}, 32'h05);
    check("ack_p4", p4, 32'h44);
    check("ack_req", {31'd0, imem.imem_req}, 32'd0);

    for (int s = 0; s < 4; s++) begin
      pcsource = s[1:0]; advance = 1'b1;
      tick();
      advance = 1'b0;
      check("sel_addr", imem.imem_addr, exp_addr[s]);
      check("sel_req", {31'd0, imem.imem_req}, 32'd1);
      check("sel_valid", {31'd0, inst_valid}, 32'd0);
      check("sel_icount", icount, 32'(s + 1));
      imem.imem_ack = 1'b1; imem.imem_rdata = 32'h1000 + 32'(s);
      tick();
      imem.imem_ack = 1'b0;
      check("sel_inst", inst, 32'h1000 + 32'(s));
    end

    jpc = 32'hFFFF_FFFC; pcsource = 2'b11; advance = 1'b1;
    tick();
    advance = 1'b0;
    check("wrap_addr", imem.imem_addr, 32'hFFFF_FFFC);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hAAAA_5555;
    tick();
    check("wrap_p4", p4, 32'd0);
    held = 32'hAAAA_5555;
    for (int i = 0; i < 5; i++) begin
      imem.imem_rdata = ~imem.imem_rdata;
      imem.imem_ack = i[0];
      tick();
      check("stall_inst", inst, held);
      check("stall_valid", {31'd0, inst_valid}, 32'd1);
    end
    imem.imem_ack = 1'b0;
    pcsource = 2'b00; advance = 1'b1;
    tick();
    advance = 1'b0;
    check("wrap_next", imem.imem_addr, 32'd0);
    check("wrap_icount", icount, 32'd6);

    // Reset while the fetch to 0 is outstanding
    reset = 1'b1;
    #1;
    check("arst_req", {31'd0, imem.imem_req}, 32'd0);
    check("arst_pc", pc, 32'h40);
    check("arst_icount", icount, 32'd0);
    tick();
    reset = 1'b0;
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem.imem_ack = 1'b0;
    check("late_req", {31'd0, imem.imem_req}, 32'd1);
    check("late_addr", imem.imem_addr, 32'h40);
    check("late_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    check("late_valid2", {31'd0, inst_valid}, 32'd0);
    check("late_inst", inst, 32'd0);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h0000_0008;
    tick();
    imem.imem_ack = 1'b0;
    check("refetch_inst", inst, 32'h0000_0008);

    rpc = 32'h202; pcsource = 2'b10; advance = 1'b1;
    tick();
    advance = 1'b0;
    check("align_icount", icount, 32'd1);
`ifdef IFU_ALIGN_CHECK_EN
    check("align_fault", {31'd0, fault}, 32'd1);
    check("align_pc", pc, 32'h202);
    for (int i = 0; i < 3; i++) begin
      imem.imem_ack = 1'b1;
      tick();
      check("fault_req", {31'd0, imem.imem_req}, 32'd0);
      check("fault_valid", {31'd0, inst_valid}, 32'd0);
    end
    imem.imem_ack = 1'b0;
`else
    check("align_addr", imem.imem_addr, 32'h200);
    check("align_req", {31'd0, imem.imem_req}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sc_ifu.md
# sc_ifu

Instruction fetch unit for the single-cycle CPU. Holds the PC, fetches each instruction from instruction memory over a request/acknowledge handshake, and presents the instruction with its `op`/`func` fields to the control unit and datapath. Computes the next PC from the control unit's `pcsource` select and the datapath's branch, register and jump targets. Sits directly upstream of the control unit.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `clock` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `pcsource` in 2: next-PC select from the control unit. 00 = pc+4, 01 = branch target, 10 = jr register, 11 = jump target.
- `bpc` in 32: branch target.
- `rpc` in 32: jr register value.
- `jpc` in 32: jump target.
- `advance` in 1: datapath has finished the presented instruction.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address.
- `imem_ack` in 1: `imem_rdata` is valid this cycle.
- `imem_rdata` in 32: fetched word.
- `inst` out 32: held instruction.
- `op` out 6: `inst[31:26]`.
- `func` out 6: `inst[5:0]`.
- `inst_valid` out 1: `inst`, `pc` and `p4` are valid.
- `pc` out 32: address of `inst`.
- `p4` out 32: `pc + 4`, used for the jal link.
- `icount` out 32: count of retired instructions.
- `fault` out 1: misaligned-target fault. Exists only with `IFU_ALIGN_CHECK_EN`.

## Operation
**States:** START, REQ, HOLD, and FAULT (FAULT only with the macro).

**Reset values:** state = START, `pc` = `RESET_PC`, `inst` = 0, `icount` = 0, `imem_req` = 0, `inst_valid` = 0, `fault` = 0.

**State transitions:**
- START: go to REQ on the next edge.
- REQ:
  - `imem_req` = 1 and `imem_addr` = `pc`; both are held stable until the ack.
  - On `imem_ack`: latch `imem_rdata` into `inst` and go to HOLD.
- HOLD:
  - `inst_valid` = 1 and `imem_req` = 0.
  - On `advance`:
    - `pc` <= npc.
    - `icount` <= `icount` + 1.
    - Go to REQ.

**Next-PC computation:**
- npc = mux(`pcsource`: `p4`, `bpc`, `rpc`, `jpc`).
- `pcsource` and the target inputs are sampled only in the HOLD cycle where `advance` = 1.
- `p4` = `pc + 4`, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- `icount` wraps from 32'hFFFF_FFFF to 0.

**Ignored inputs:**
- `advance` is ignored outside HOLD.
- `imem_ack` is ignored outside REQ.

**Outputs:**
- `op` and `func` are combinational slices of `inst`.
- `op` and `func` are meaningful only when `inst_valid` = 1.
- The held `inst` does not change during HOLD, regardless of `imem_rdata`.

**Reset during operation:** a reset asserted during REQ abandons the outstanding fetch. `imem_req` drops asynchronously and a late ack after reset is ignored.

## Timing
- Fetch latency: an ack in the same cycle as the request gives `inst_valid` = 1 on the next cycle.
- Each cycle of ack delay adds one cycle.
- Minimum throughput: 2 cycles per instruction (REQ, HOLD).
- The first request appears in the second cycle after reset deasserts.
- `advance` in HOLD gives a new `imem_addr` = npc with `imem_req` = 1 in the next cycle, and `inst_valid` = 0 in that cycle.
- All outputs are registered except `op`, `func` and `p4`, which are combinational from registers.

## Configuration
The alignment check is controlled by `IFU_ALIGN_CHECK_EN`.

With the macro defined:
- On an `advance` where npc[1:0] != 0:
  - Go to FAULT.
  - `pc` <= the misaligned npc.
  - `icount` is incremented.
  - `fault` = 1.
- In FAULT:
  - `imem_req` = 0 and `inst_valid` = 0.
  - The block leaves FAULT only on reset.

Without the macro:
- npc[1:0] is forced to 2'b00.
- There is no `fault` port and no FAULT state.

## Test plan
- **Reset:** assert `reset` with `RESET_PC` = 32'h0000_0040 → `imem_req` = 1 and `imem_addr` = 0x40 in the second cycle after release. `inst_valid` = 0 until the ack.
- **Delayed ack:** hold `imem_ack` low for 3 cycles → `imem_addr` stays at 0x40 throughout. The ack with `imem_rdata` = 32'h2008_0005 gives `inst_valid` = 1, `op` = 6'b001000, `func` = 6'b000101, and `p4` = 0x44.
- **pcsource select:**
  - With `bpc` = 0x100, `rpc` = 0x200 and `jpc` = 0x300, `advance` with each `pcsource` value 00/01/10/11 → the next `imem_addr` is 0x44, 0x100, 0x200 and 0x300 respectively.
  - `icount` increments by 1 per `advance`.
- **Wrap and stall:** at `pc` = 32'hFFFF_FFFC with `pcsource` = 00, `advance` → next `imem_addr` = 0. Holding `advance` low for 5 cycles in HOLD keeps `inst` unchanged while `imem_rdata` toggles.
- **Reset during fetch:** assert `reset` during REQ with no ack → `imem_req` drops immediately. An ack one cycle after release is ignored, and the fetch restarts at `RESET_PC`.
- **Alignment check (`IFU_ALIGN_CHECK_EN`):** `rpc` = 0x202 with `pcsource` = 10, `advance` → `fault` = 1, `pc` = 0x202, `imem_req` held 0 until reset. Without the macro, the next `imem_addr` = 0x200.
